// File: rtl/router_pkt_fifo.sv
// Per-channel packet FIFO for the 1x3 router: stores {lfd, byte} entries, tracks packet
// boundaries on both sides and reports complete-packet count, almost-full and overflow.
module router_pkt_fifo #(
   parameter int DATA_W    = 8,
   parameter int ADDR_BITS = 2,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = 14,
   parameter int PCNT_W    = 5
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              soft_rst,
   input  logic              wr_en,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] d_in,
   input  logic              rd_en,
   output logic [DATA_W-1:0] d_out,
   output logic              d_valid,
   output logic              sof_out,
   output logic              eop_out,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic [PCNT_W-1:0] pkt_cnt,
   output logic              overflow
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LEN_W = DATA_W - ADDR_BITS;
   localparam int CW    = LEN_W + 1;

   logic [DATA_W:0]   mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       occ;
   logic [CW-1:0]     wcnt, rcnt;
   logic [CW-1:0]     wr_len1, rd_len1;
   logic [DATA_W:0]   rd_entry;
   logic              rd_lfd;
   logic              flush, wr_acc, rd_acc, wr_done, rd_done;

   assign flush       = rstn | soft_rst;
   assign empty       = (occ == '0);
   assign full        = (occ == (AW+1)'(DEPTH));
   assign almost_full = (occ >= (AW+1)'(AFULL_TH));

   // Acceptance uses registered occupancy only: a same-cycle pop never frees a slot
   // for a write, and a write into an empty FIFO is never bypassed to the read side.
   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   assign rd_entry = mem[rd_ptr];
   assign rd_lfd   = rd_entry[DATA_W];
   assign wr_len1  = {1'b0, d_in[DATA_W-1:ADDR_BITS]} + CW'(1);
   assign rd_len1  = {1'b0, rd_entry[DATA_W-1:ADDR_BITS]} + CW'(1);

   assign wr_done = wr_acc & ~lfd_state & (wcnt == CW'(1));
   assign rd_done = rd_acc & ~rd_lfd & (rcnt == CW'(1));

   // Array is deliberately left uncleared on flush.
   always_ff @(posedge clk) begin
      if (!flush && wr_acc)
         mem[wr_ptr] <= {lfd_state, d_in};
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: occ <= occ;
         endcase
      end
   end

   // A header always reloads, abandoning any partially written packet.
   always_ff @(posedge clk) begin
      if (flush)
         wcnt <= '0;
      else if (wr_acc) begin
         if (lfd_state)
            wcnt <= wr_len1;
         else if (wcnt != '0)
            wcnt <= wcnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (flush)
         rcnt <= '0;
      else if (rd_acc) begin
         if (rd_lfd)
            rcnt <= rd_len1;
         else if (rcnt != '0)
            rcnt <= rcnt - CW'(1);
      end
   end

   // sof/eop are qualified pulses; d_out itself holds across idle cycles.
   always_ff @(posedge clk) begin
      if (flush) begin
         d_out    <= '0;
         d_valid  <= 1'b0;
         sof_out  <= 1'b0;
         eop_out  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         overflow <= wr_en & full;
         d_valid  <= rd_acc;
         sof_out  <= rd_acc & rd_lfd;
         eop_out  <= rd_done;
         if (rd_acc)
            d_out <= rd_entry[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (flush)
         pkt_cnt <= '0;
      else if (wr_done && !rd_done) begin
         if (pkt_cnt != {PCNT_W{1'b1}})
            pkt_cnt <= pkt_cnt + PCNT_W'(1);
      end else if (rd_done && !wr_done) begin
         if (pkt_cnt != '0)
            pkt_cnt <= pkt_cnt - PCNT_W'(1);
      end
   end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Scoreboard bench for router_pkt_fifo: stimulus queues expected read bytes, a negedge
// monitor pops and compares whenever d_valid is presented.
module tb_router_pkt_fifo;

   logic       clk = 1'b0;
   logic       rstn, soft_rst, wr_en, lfd_state, rd_en;
   logic [7:0] d_in;
   logic [7:0] d_out;
   logic       d_valid, sof_out, eop_out, empty, full, almost_full, overflow;
   logic [4:0] pkt_cnt;

   typedef struct packed {
      logic [7:0] d;
      logic       sof;
      logic       eop;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   router_pkt_fifo #(.DATA_W(8), .ADDR_BITS(2), .DEPTH(16), .AFULL_TH(14), .PCNT_W(5)) dut (
      .clk(clk), .rstn(rstn), .soft_rst(soft_rst), .wr_en(wr_en), .lfd_state(lfd_state),
      .d_in(d_in), .rd_en(rd_en), .d_out(d_out), .d_valid(d_valid), .sof_out(sof_out),
      .eop_out(eop_out), .empty(empty), .full(full), .almost_full(almost_full),
      .pkt_cnt(pkt_cnt), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Outputs are sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (d_valid === 1'b1) begin
         exp_t e;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected got=%0h exp=none", d_out);
         end else begin
            e = exp_q.pop_front();
            if (d_out !== e.d || sof_out !== e.sof || eop_out !== e.eop) begin
               failures++;
               $display("FAIL rd_data got=%0h/sof%0b/eop%0b exp=%0h/sof%0b/eop%0b",
                        d_out, sof_out, eop_out, e.d, e.sof, e.eop);
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] d, input logic lfd);
      wr_en = 1'b1; d_in = d; lfd_state = lfd;
      cycle();
      wr_en = 1'b0; lfd_state = 1'b0;
   endtask

   task automatic rd(input logic [7:0] d, input logic s, input logic e);
      rd_en = 1'b1;
      exp_q.push_back('{d: d, sof: s, eop: e});
      cycle();
      rd_en = 1'b0;
   endtask

   initial begin
      rstn = 1'b1; soft_rst = 1'b0; wr_en = 1'b0; lfd_state = 1'b0; rd_en = 1'b0; d_in = '0;
      cycle();
      rstn = 1'b0;
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_d_valid", d_valid, 0);
      chk("rst_d_out", d_out, 8'h00);

      // Header 0x3A: len 14, addr 2 -> 16 bytes fill the FIFO exactly
      wr(8'h3A, 1'b1);
      for (int i = 0; i < 14; i++) begin
         wr(8'h10 + 8'(i), 1'b0);
         if (i == 11) chk("afull_at_13", almost_full, 0);
         if (i == 12) chk("afull_at_14", almost_full, 1);
      end
      chk("pkt_cnt_before_parity", pkt_cnt, 0);
      wr(8'hA5, 1'b0);
      chk("pkt_cnt_single", pkt_cnt, 1);
      chk("full_single", full, 1);

      wr(8'h55, 1'b0);
      chk("overflow_pulse", overflow, 1);
      chk("overflow_full", full, 1);
      cycle();
      chk("overflow_clear", overflow, 0);
      chk("overflow_pkt_cnt", pkt_cnt, 1);

      rd(8'h3A, 1'b1, 1'b0);
      for (int i = 0; i < 14; i++) rd(8'h10 + 8'(i), 1'b0, 1'b0);
      rd(8'hA5, 1'b0, 1'b1);
      chk("drain_pkt_cnt", pkt_cnt, 0);
      chk("drain_empty", empty, 1);

      // Read on empty is ignored and d_out holds
      rd_en = 1'b1; cycle(); rd_en = 1'b0;
      chk("rd_empty_valid", d_valid, 0);
      chk("rd_empty_hold", d_out, 8'hA5);

      // Two zero-length packets
      wr(8'h01, 1'b1); wr(8'h11, 1'b0);
      wr(8'h02, 1'b1); wr(8'h22, 1'b0);
      chk("zlen_pkt_cnt", pkt_cnt, 2);
      rd(8'h01, 1'b1, 1'b0); rd(8'h11, 1'b0, 1'b1);
      chk("zlen_pkt_cnt_mid", pkt_cnt, 1);
      rd(8'h02, 1'b1, 1'b0); rd(8'h22, 1'b0, 1'b1);
      chk("zlen_pkt_cnt_end", pkt_cnt, 0);

      // Steady state at occupancy 8 with simultaneous read/write; pointers wrap
      for (int i = 0; i < 8; i++) wr(8'h80 + 8'(i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         wr_en = 1'b1; d_in = 8'h90 + 8'(i); rd_en = 1'b1;
         exp_q.push_back('{d: (i < 8) ? 8'h80 + 8'(i) : 8'h90 + 8'(i - 8), sof: 1'b0, eop: 1'b0});
         cycle();
      end
      wr_en = 1'b0; rd_en = 1'b0;
      chk("rw_afull", almost_full, 0);
      chk("rw_pkt_cnt", pkt_cnt, 0);
      for (int i = 0; i < 8; i++) begin
         chk("rw_not_empty", empty, 0);
         rd(8'h9C + 8'(i), 1'b0, 1'b0);
      end
      chk("rw_empty", empty, 1);

      // Mid-packet flush with a write attempted in the flush cycle
      wr(8'h28, 1'b1);
      for (int i = 0; i < 5; i++) wr(8'h40 + 8'(i), 1'b0);
      soft_rst = 1'b1; wr_en = 1'b1; d_in = 8'h77;
      cycle();
      soft_rst = 1'b0; wr_en = 1'b0;
      chk("flush_empty", empty, 1);
      chk("flush_pkt_cnt", pkt_cnt, 0);
      chk("flush_d_out", d_out, 8'h00);
      chk("flush_d_valid", d_valid, 0);
      wr(8'h03, 1'b1); wr(8'h33, 1'b0);
      chk("post_flush_pkt_cnt", pkt_cnt, 1);
      rd(8'h03, 1'b1, 1'b0); rd(8'h33, 1'b0, 1'b1);
      chk("post_flush_empty", empty, 1);
      chk("post_flush_pkt_end", pkt_cnt, 0);

      cycle(); cycle();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
Parametrised per-channel packet FIFO for the 1x3 router, the successor to fifo_router. It stores header, payload and parity bytes tagged with the header (lfd) flag. It tracks packet boundaries on both the write and read sides, and reports the number of complete packets buffered. It also provides almost-full, overflow and start-of-packet indications to the router FSM and sync block.

Parameters:
DATA_W, 8, byte width; header layout is {payload_len[DATA_W-1:ADDR_BITS], addr[ADDR_BITS-1:0]}
ADDR_BITS, 2, width of the destination-address field in the header
DEPTH, 16, number of entries; must be a power of 2 and at least 4
AFULL_TH, 14, occupancy at or above which almost_full asserts; range 1..DEPTH
PCNT_W, 5, width of pkt_cnt

Ports:
clk  in  1  rising-edge clock
rstn  in  1  reset: synchronous, active-high (asserted = 1); name kept per codebase convention
soft_rst  in  1  synchronous channel flush from the sync block (timeout)
wr_en  in  1  write strobe
lfd_state  in  1  marks d_in as a header byte
d_in  in  DATA_W  write data
rd_en  in  1  read strobe
d_out  out  DATA_W  registered read data
d_valid  out  1  d_out holds a byte popped on the previous cycle
sof_out  out  1  d_out is a header byte (stored lfd flag)
eop_out  out  1  d_out is the parity byte (last byte of its packet)
empty  out  1  occupancy == 0
full  out  1  occupancy == DEPTH
almost_full  out  1  occupancy >= AFULL_TH
pkt_cnt  out  PCNT_W  number of complete packets stored
overflow  out  1  one-cycle pulse when a write is dropped because the FIFO is full

Behaviour:
- Storage: DEPTH x (DATA_W+1) array holding {lfd, data}.
- Pointers: wr_ptr and rd_ptr, log2(DEPTH) bits each, wrap modulo DEPTH.
- Occupancy: counter of log2(DEPTH)+1 bits; empty, full and almost_full decode combinationally from it.
- Write acceptance: a write is accepted when wr_en=1 and full=0. wr_en=1 with full=1 drops the byte, pulses overflow, and leaves all state unchanged. The full check uses the registered occupancy, so a read in the same cycle does not free a slot for that write.
- Read acceptance: a read is accepted when rd_en=1 and empty=0. The byte appears on d_out the next cycle with d_valid=1, and sof_out/eop_out aligned to it.
- Read on empty: ignored; d_valid=0 and d_out holds its last value.
- Read latency: 1 cycle.
- Simultaneous accepted read and write: occupancy unchanged. On an empty FIFO only the write is accepted.
- Write-side packet counter (wcnt, DATA_W-ADDR_BITS+1 bits):
  - An accepted write with lfd_state=1 loads wcnt = payload_len+1.
  - Each subsequent accepted non-header write decrements wcnt.
  - The write that decrements wcnt from 1 to 0 is the parity byte; it increments pkt_cnt.
  - A header arriving while wcnt != 0 abandons the old count and reloads.
- Read-side packet counter (rcnt):
  - Popping an entry whose stored lfd=1 loads rcnt = payload_len+1 from that entry.
  - Each further pop decrements rcnt.
  - The pop taking rcnt from 1 to 0 sets eop_out=1 on the following cycle and decrements pkt_cnt.
- Zero-length packet: payload_len=0 is legal; the packet is 2 bytes (header, parity).
- pkt_cnt on simultaneous events: a complete-write and a complete-read in the same cycle leave pkt_cnt unchanged. pkt_cnt saturates at 2^PCNT_W-1 and never underflows.
- Reset (rstn=1) or soft_rst=1, taking priority over everything:
  - pointers, occupancy, wcnt, rcnt and pkt_cnt clear to 0;
  - d_out=0, d_valid=0, sof_out=0, eop_out=0, overflow=0;
  - empty=1, full=0, almost_full=0.
  - Array contents are not cleared.
  - Any write or read in that cycle is discarded.
- After flush: the next accepted write must be a header; non-header writes with wcnt=0 are stored but not counted toward pkt_cnt.
- No combinational path from rd_en/wr_en to d_out. Single clock domain.

Test Plan:
- Reset: pulse rstn=1 for 1 cycle -> empty=1, full=0, pkt_cnt=0, d_valid=0, d_out=0x00.
- Single packet: write header 0x3A (len=14, addr=2) with lfd_state=1, then 14 payload bytes and 1 parity byte -> after parity write pkt_cnt=1 and occupancy 16 so full=1. Then 16 reads -> first d_out=0x3A with sof_out=1, 16th with eop_out=1, pkt_cnt=0, empty=1.
- Overflow: FIFO full, wr_en=1 with d_in=0x55 -> overflow pulses 1 cycle, occupancy stays 16, byte 0x55 never read back.
- Back-to-back zero-length packets: headers 0x01 and 0x02, each followed by one parity byte -> pkt_cnt=2. Read out -> eop_out on the 2nd and 4th reads.
- Simultaneous read/write at occupancy 8 for 20 cycles -> occupancy stays 8, data is returned in order, and wr_ptr/rd_ptr wrap without error.
- Mid-packet soft_rst: after header plus 5 payload bytes, soft_rst=1 -> empty=1, pkt_cnt=0. A following 2-byte packet is read back intact with sof_out/eop_out correct.
